// File: rtl/ascon_perm_ctrl_if.sv
// Handshake and datapath-control bundle between the ASCON round sequencer
// and whatever drives it. The master side issues requests; the slave side
// (the sequencer) returns the datapath controls and status.
interface ascon_perm_ctrl_if;
  logic       start_i;
  logic       mode_i;
  logic       stall_i;
  logic       abort_i;
  logic       sel_o;
  logic [3:0] round_o;
  logic       en_o;
  logic       busy_o;
  logic       done_o;

  modport master (
    output start_i, mode_i, stall_i, abort_i,
    input  sel_o, round_o, en_o, busy_o, done_o
  );

  modport slave (
    input  start_i, mode_i, stall_i, abort_i,
    output sel_o, round_o, en_o, busy_o, done_o
  );
endinterface

// File: rtl/ascon_perm_ctrl.sv
// Moore sequencer for the iterated ASCON round datapath. Walks the round
// counter from 0 (p12) or 6 (p6) up to 11, steering the input mux, the
// round-constant index and the state-register enable. Everything except
// en_o is decoded from the state and counter registers; en_o also looks at
// stall/abort so a frozen or cancelled round never writes the state.
module ascon_perm_ctrl (
  input  logic                clock_i,
  input  logic                resetb_i,
  ascon_perm_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'd11;
  localparam logic [3:0] P6_ROUND   = 4'd6;

  state_t     state_q, state_d;
  logic [3:0] round_q, round_d;

  // State and round counter registers, cleared asynchronously.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q <= IDLE;
      round_q <= 4'd0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  // Next-state and counter update; abort beats stall, DONE always retires.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    case (state_q)
      IDLE: begin
        if (bus.start_i && !bus.abort_i) begin
          state_d = FIRST;
          round_d = bus.mode_i ? P6_ROUND : 4'd0;
        end
      end
      FIRST: begin
        if (bus.abort_i) begin
          state_d = IDLE;
          round_d = 4'd0;
        end else if (!bus.stall_i) begin
          state_d = RUN;
          round_d = round_q + 4'd1;
        end
      end
      RUN: begin
        if (bus.abort_i) begin
          state_d = IDLE;
          round_d = 4'd0;
        end else if (!bus.stall_i) begin
          // Counter parks at the last round; it never wraps past 11.
          if (round_q == LAST_ROUND) begin
            state_d = DONE;
          end else begin
            round_d = round_q + 4'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        round_d = 4'd0;
      end
      default: begin
        state_d = IDLE;
        round_d = 4'd0;
      end
    endcase
  end

  // Output decode; the counter still holds 11 while in DONE.
  always_comb begin
    bus.sel_o   = (state_q == RUN) || (state_q == DONE);
    bus.round_o = (state_q == IDLE) ? 4'd0 : round_q;
    bus.busy_o  = (state_q != IDLE);
    bus.done_o  = (state_q == DONE);
    bus.en_o    = ((state_q == FIRST) || (state_q == RUN)) &&
                  !bus.stall_i && !bus.abort_i;
  end

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Directed bench for ascon_perm_ctrl. Each step pushes the inputs to drive
// for one cycle together with the outputs expected in that cycle; the queue
// is then drained cycle by cycle and the DUT outputs are compared mid-cycle.
module tb_ascon_perm_ctrl;

  logic clock_i  = 1'b0;
  logic resetb_i = 1'b0;

  ascon_perm_ctrl_if bus ();

  ascon_perm_ctrl dut (
    .clock_i  (clock_i),
    .resetb_i (resetb_i),
    .bus      (bus)
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    logic       start;
    logic       mode;
    logic       stall;
    logic       abort;
    logic [7:0] exp;
    string      tag;
  } step_t;

  step_t sb_q[$];
  int checks     = 0;
  int errors     = 0;
  int done_seen  = 0;

  // Packs {sel, round, en, busy, done}.
  function automatic logic [7:0] pk(input logic sel, input logic [3:0] rnd,
                                    input logic en, input logic busy,
                                    input logic done);
    return {sel, rnd, en, busy, done};
  endfunction

  function automatic logic [7:0] observed();
    return {bus.sel_o, bus.round_o, bus.en_o, bus.busy_o, bus.done_o};
  endfunction

  task automatic push(input logic st, input logic md, input logic sl,
                      input logic ab, input logic [7:0] e, input string tag);
    step_t s;
    s.start = st;
    s.mode  = md;
    s.stall = sl;
    s.abort = ab;
    s.exp   = e;
    s.tag   = tag;
    sb_q.push_back(s);
  endtask

  task automatic push_idle(input logic st, input logic md, input logic ab,
                           input string tag);
    push(st, md, 1'b0, ab, pk(1'b0, 4'd0, 1'b0, 1'b0, 1'b0), tag);
  endtask

  // Unstalled rounds first..11 followed by the DONE cycle.
  task automatic push_perm(input int first, input logic st, input logic md,
                           input string tag);
    for (int r = first; r <= 11; r++) begin
      push(st, md, 1'b0, 1'b0,
           pk((r != first), 4'(r), 1'b1, 1'b1, 1'b0), tag);
    end
    push(st, md, 1'b0, 1'b0, pk(1'b1, 4'd11, 1'b0, 1'b1, 1'b1), tag);
  endtask

  // Drains the queue: drive after a rising edge, check at the falling edge.
  task automatic run_queue();
    step_t s;
    logic [7:0] obs;
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      bus.start_i = s.start;
      bus.mode_i  = s.mode;
      bus.stall_i = s.stall;
      bus.abort_i = s.abort;
      @(negedge clock_i);
      obs = observed();
      if (bus.done_o) done_seen++;
      checks++;
      assert (obs === s.exp) else begin
        errors++;
        $error("FAIL %s: observed sel/round/en/busy/done=%b required %b",
               s.tag, obs, s.exp);
      end
      @(posedge clock_i);
      #1;
    end
    bus.start_i = 1'b0;
    bus.mode_i  = 1'b0;
    bus.stall_i = 1'b0;
    bus.abort_i = 1'b0;
  endtask

  initial begin
    bus.start_i = 1'b0;
    bus.mode_i  = 1'b0;
    bus.stall_i = 1'b0;
    bus.abort_i = 1'b0;
    @(posedge clock_i);
    #1;

    // Reset held: outputs at idle values even with a start request.
    push(1'b1, 1'b0, 1'b0, 1'b0, pk(1'b0, 4'd0, 1'b0, 1'b0, 1'b0), "reset");
    push_idle(1'b0, 1'b0, 1'b0, "reset");
    run_queue();
    resetb_i = 1'b1;

    // p12 unstalled: done at T0+13.
    push_idle(1'b1, 1'b0, 1'b0, "p12_accept");
    push_perm(0, 1'b0, 1'b0, "p12");
    push_idle(1'b0, 1'b0, 1'b0, "p12_idle");
    run_queue();

    // p6 unstalled: done at T0+7.
    push_idle(1'b1, 1'b1, 1'b0, "p6_accept");
    push_perm(6, 1'b0, 1'b0, "p6");
    push_idle(1'b0, 1'b0, 1'b0, "p6_idle");
    run_queue();

    // p12 with a three-cycle stall on round 4: done at T0+16.
    push_idle(1'b1, 1'b0, 1'b0, "stall_accept");
    for (int r = 0; r <= 3; r++)
      push(1'b0, 1'b0, 1'b0, 1'b0, pk((r != 0), 4'(r), 1'b1, 1'b1, 1'b0), "stall_pre");
    for (int k = 0; k < 3; k++)
      push(1'b0, 1'b0, 1'b1, 1'b0, pk(1'b1, 4'd4, 1'b0, 1'b1, 1'b0), "stall_hold");
    for (int r = 4; r <= 11; r++)
      push(1'b0, 1'b0, 1'b0, 1'b0, pk(1'b1, 4'(r), 1'b1, 1'b1, 1'b0), "stall_post");
    push(1'b0, 1'b0, 1'b0, 1'b0, pk(1'b1, 4'd11, 1'b0, 1'b1, 1'b1), "stall_done");
    push_idle(1'b0, 1'b0, 1'b0, "stall_idle");
    run_queue();

    // Abort on round 7 with a stray start mid-run: no done at all.
    done_seen = 0;
    push_idle(1'b1, 1'b0, 1'b0, "abort_accept");
    for (int r = 0; r <= 6; r++)
      push((r == 3), (r == 3), 1'b0, 1'b0,
           pk((r != 0), 4'(r), 1'b1, 1'b1, 1'b0), "abort_pre");
    push(1'b0, 1'b0, 1'b0, 1'b1, pk(1'b1, 4'd7, 1'b0, 1'b1, 1'b0), "abort_r7");
    push_idle(1'b0, 1'b0, 1'b0, "abort_idle");
    push_idle(1'b0, 1'b0, 1'b0, "abort_idle");
    run_queue();
    checks++;
    assert (done_seen === 0) else begin
      errors++;
      $error("FAIL abort_done_count: observed %0d required 0", done_seen);
    end

    // Abort together with stall in FIRST: abort wins.
    push_idle(1'b1, 1'b1, 1'b0, "abortf_accept");
    push(1'b0, 1'b0, 1'b1, 1'b1, pk(1'b0, 4'd6, 1'b0, 1'b1, 1'b0), "abortf_first");
    push_idle(1'b0, 1'b0, 1'b0, "abortf_idle");
    // Start and abort together in IDLE: stay idle.
    push_idle(1'b1, 1'b0, 1'b1, "start_abort");
    push_idle(1'b0, 1'b0, 1'b0, "start_abort_idle");
    run_queue();

    // p6 with a stall in FIRST, a stall at round 11, and abort in DONE.
    push_idle(1'b1, 1'b1, 1'b0, "misc_accept");
    push(1'b0, 1'b0, 1'b1, 1'b0, pk(1'b0, 4'd6, 1'b0, 1'b1, 1'b0), "misc_first_stall");
    push(1'b0, 1'b0, 1'b0, 1'b0, pk(1'b0, 4'd6, 1'b1, 1'b1, 1'b0), "misc_first");
    for (int r = 7; r <= 10; r++)
      push(1'b0, 1'b0, 1'b0, 1'b0, pk(1'b1, 4'(r), 1'b1, 1'b1, 1'b0), "misc_run");
    push(1'b0, 1'b0, 1'b1, 1'b0, pk(1'b1, 4'd11, 1'b0, 1'b1, 1'b0), "misc_r11_stall");
    push(1'b0, 1'b0, 1'b0, 1'b0, pk(1'b1, 4'd11, 1'b1, 1'b1, 1'b0), "misc_r11");
    push(1'b0, 1'b0, 1'b0, 1'b1, pk(1'b1, 4'd11, 1'b0, 1'b1, 1'b1), "misc_done_abort");
    push_idle(1'b0, 1'b0, 1'b0, "misc_idle");
    run_queue();

    // Reset pulse during round 5 of p12, then a clean p6.
    push_idle(1'b1, 1'b0, 1'b0, "rst_accept");
    for (int r = 0; r <= 4; r++)
      push(1'b0, 1'b0, 1'b0, 1'b0, pk((r != 0), 4'(r), 1'b1, 1'b1, 1'b0), "rst_pre");
    run_queue();
    resetb_i = 1'b0;
    #1;
    checks++;
    assert (observed() === pk(1'b0, 4'd0, 1'b0, 1'b0, 1'b0)) else begin
      errors++;
      $error("FAIL rst_async: observed %b required %b",
             observed(), pk(1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
    end
    #2;
    resetb_i = 1'b1;
    @(posedge clock_i);
    #1;
    push_idle(1'b0, 1'b0, 1'b0, "rst_after");
    push_idle(1'b1, 1'b1, 1'b0, "rst_p6_accept");
    push_perm(6, 1'b0, 1'b0, "rst_p6");
    push_idle(1'b0, 1'b0, 1'b0, "rst_p6_idle");
    run_queue();

    // Start held high: one IDLE cycle between runs; mode ignored while busy.
    push_idle(1'b1, 1'b1, 1'b0, "cont_accept0");
    push_perm(6, 1'b1, 1'b1, "cont_run0");
    push_idle(1'b1, 1'b1, 1'b0, "cont_accept1");
    push_perm(6, 1'b1, 1'b0, "cont_run1");
    push_idle(1'b0, 1'b0, 1'b0, "cont_idle");
    run_queue();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
